// File: rtl/download_fsm_datapath.sv
// Flit-to-message assembler: collects head/addrhi/addrlo plus up to eight data
// flits, presents the message until acknowledged, and flags protocol errors.
module download_fsm_datapath (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_flit_in,
  input  logic [15:0]  flit_in,
  input  logic [1:0]   ctrl_in,
  input  logic         msg_ack_in,
  output logic         rdy_out,
  output logic         v_msg_out,
  output logic [15:0]  head_flit_out,
  output logic [15:0]  addrhi_out,
  output logic [15:0]  addrlo_out,
  output logic [127:0] data_out,
  output logic [3:0]   flit_cnt_out,
  output logic [1:0]   fsm_state,
  output logic         err_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    DONE = 2'b10,
    DROP = 2'b11
  } state_e;

  localparam logic [1:0] CT_HEAD = 2'b01;
  localparam logic [1:0] CT_TAIL = 2'b11;
  localparam logic [3:0] CNT_MAX = 4'd11;

  state_e       state_q;
  logic [3:0]   cnt_q;
  logic [15:0]  head_q;
  logic [15:0]  addrhi_q;
  logic [15:0]  addrlo_q;
  logic [127:0] data_q;
  logic [3:0]   flit_cnt_q;
  logic         err_q;

  logic         accept;
  logic [3:0]   cnt_nxt;
  logic [3:0]   widx;

  assign rdy_out       = (state_q != DONE);
  assign v_msg_out     = (state_q == DONE);
  assign accept        = v_flit_in & rdy_out;
  assign cnt_nxt       = cnt_q + 4'd1;
  assign widx          = cnt_q - 4'd3;
  assign fsm_state     = state_q;
  assign head_flit_out = head_q;
  assign addrhi_out    = addrhi_q;
  assign addrlo_out    = addrlo_q;
  assign data_out      = data_q;
  assign flit_cnt_out  = flit_cnt_q;
  assign err_out       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      head_q     <= 16'd0;
      addrhi_q   <= 16'd0;
      addrlo_q   <= 16'd0;
      data_q     <= 128'd0;
      flit_cnt_q <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE, RECV: begin
          if (accept) begin
            if (ctrl_in == CT_HEAD) begin
              // A head inside a message is an error but still starts a fresh one.
              err_q    <= (state_q == RECV);
              head_q   <= flit_in;
              addrhi_q <= 16'd0;
              addrlo_q <= 16'd0;
              data_q   <= 128'd0;
              cnt_q    <= 4'd1;
              state_q  <= RECV;
            end else if (state_q == IDLE || ctrl_in == 2'b00) begin
              err_q <= 1'b1;
            end else if (cnt_q >= CNT_MAX) begin
              err_q <= 1'b1;
              if (ctrl_in == CT_TAIL) begin
                state_q <= IDLE;
                cnt_q   <= 4'd0;
              end else begin
                state_q <= DROP;
              end
            end else begin
              case (cnt_q)
                4'd1:    addrhi_q <= flit_in;
                4'd2:    addrlo_q <= flit_in;
                default: data_q[{widx[2:0], 4'b0000} +: 16] <= flit_in;
              endcase
              cnt_q <= cnt_nxt;
              if (ctrl_in == CT_TAIL) begin
                if (cnt_nxt >= 4'd3) begin
                  flit_cnt_q <= cnt_nxt;
                  state_q    <= DONE;
                end else begin
                  err_q   <= 1'b1;
                  cnt_q   <= 4'd0;
                  state_q <= IDLE;
                end
              end
            end
          end
        end
        DONE: begin
          if (msg_ack_in) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end
        end
        DROP: begin
          if (accept && ctrl_in == CT_TAIL) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_download_fsm_datapath.sv
// Directed bench for the flit-to-message assembler; expected values are hand-computed.
module tb_download_fsm_datapath;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         v_flit_in = 1'b0;
  logic [15:0]  flit_in = 16'd0;
  logic [1:0]   ctrl_in = 2'b00;
  logic         msg_ack_in = 1'b0;
  logic         rdy_out;
  logic         v_msg_out;
  logic [15:0]  head_flit_out;
  logic [15:0]  addrhi_out;
  logic [15:0]  addrlo_out;
  logic [127:0] data_out;
  logic [3:0]   flit_cnt_out;
  logic [1:0]   fsm_state;
  logic         err_out;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [1:0] HD = 2'b01, BD = 2'b10, TL = 2'b11, IL = 2'b00;
  localparam logic [1:0] S_IDLE = 2'b00, S_RECV = 2'b01, S_DONE = 2'b10, S_DROP = 2'b11;

  download_fsm_datapath dut (
    .clk(clk), .rst(rst), .v_flit_in(v_flit_in), .flit_in(flit_in), .ctrl_in(ctrl_in),
    .msg_ack_in(msg_ack_in), .rdy_out(rdy_out), .v_msg_out(v_msg_out),
    .head_flit_out(head_flit_out), .addrhi_out(addrhi_out), .addrlo_out(addrlo_out),
    .data_out(data_out), .flit_cnt_out(flit_cnt_out), .fsm_state(fsm_state), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [1:0] c, input logic [15:0] f);
    @(negedge clk);
    v_flit_in = 1'b1; ctrl_in = c; flit_in = f;
    @(posedge clk); #1;
    v_flit_in = 1'b0; ctrl_in = IL; flit_in = 16'd0;
  endtask

  task automatic ack();
    @(negedge clk);
    msg_ack_in = 1'b1;
    @(posedge clk); #1;
    msg_ack_in = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    tests_run++; if (fsm_state !== S_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0h want 0", fsm_state); end
    tests_run++; if (rdy_out !== 1'b1 || v_msg_out !== 1'b0 || err_out !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: rdy=%b v=%b err=%b want 1 0 0", rdy_out, v_msg_out, err_out); end
    tests_run++; if ({head_flit_out, addrhi_out, addrlo_out, data_out, flit_cnt_out} !== 180'd0) begin tests_failed++; $display("FAIL reset_msg: got nonzero message regs, want 0"); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_short_msg();
    send(HD, 16'h1234); send(BD, 16'hAAAA); send(TL, 16'h5555);
    tests_run++; if (v_msg_out !== 1'b1 || fsm_state !== S_DONE || rdy_out !== 1'b0) begin tests_failed++; $display("FAIL short_done: v=%b st=%0h rdy=%b want 1 2 0", v_msg_out, fsm_state, rdy_out); end
    tests_run++; if (head_flit_out !== 16'h1234 || addrhi_out !== 16'hAAAA || addrlo_out !== 16'h5555) begin tests_failed++; $display("FAIL short_fields: got %h %h %h want 1234 aaaa 5555", head_flit_out, addrhi_out, addrlo_out); end
    tests_run++; if (data_out !== 128'd0 || flit_cnt_out !== 4'd3) begin tests_failed++; $display("FAIL short_data_cnt: data=%h cnt=%0d want 0 3", data_out, flit_cnt_out); end
    tests_run++; if (err_out !== 1'b0) begin tests_failed++; $display("FAIL short_noerr: got %b want 0", err_out); end
    ack();
    tests_run++; if (fsm_state !== S_IDLE || rdy_out !== 1'b1 || v_msg_out !== 1'b0) begin tests_failed++; $display("FAIL short_ack: st=%0h rdy=%b v=%b want 0 1 0", fsm_state, rdy_out, v_msg_out); end
    tests_run++; if (head_flit_out !== 16'h1234 || flit_cnt_out !== 4'd3) begin tests_failed++; $display("FAIL short_hold: head=%h cnt=%0d want 1234 3", head_flit_out, flit_cnt_out); end
  endtask

  task automatic test_full_msg();
    logic [127:0] exp_data;
    exp_data = {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    send(HD, 16'hC0DE); send(BD, 16'h1111); send(BD, 16'h2222);
    for (int k = 1; k <= 7; k++) send(BD, 16'(k));
    tests_run++; if (fsm_state !== S_RECV || err_out !== 1'b0) begin tests_failed++; $display("FAIL full_at10: st=%0h err=%b want 1 0", fsm_state, err_out); end
    send(TL, 16'h0008);
    tests_run++; if (v_msg_out !== 1'b1 || flit_cnt_out !== 4'd11) begin tests_failed++; $display("FAIL full_done: v=%b cnt=%0d want 1 11", v_msg_out, flit_cnt_out); end
    tests_run++; if (data_out[15:0] !== 16'h0001 || data_out[127:112] !== 16'h0008) begin tests_failed++; $display("FAIL full_ends: lo=%h hi=%h want 0001 0008", data_out[15:0], data_out[127:112]); end
    tests_run++; if (data_out !== exp_data || addrhi_out !== 16'h1111 || addrlo_out !== 16'h2222) begin tests_failed++; $display("FAIL full_data: got %h want %h", data_out, exp_data); end
    ack();
    tests_run++; if (fsm_state !== S_IDLE || rdy_out !== 1'b1) begin tests_failed++; $display("FAIL full_ack: st=%0h rdy=%b want 0 1", fsm_state, rdy_out); end
  endtask

  task automatic test_back_to_back();
    send(HD, 16'h0A0A); send(BD, 16'h0B0B); send(TL, 16'h0C0C);
    ack();
    send(HD, 16'h0D0D);
    tests_run++; if (fsm_state !== S_RECV || head_flit_out !== 16'h0D0D) begin tests_failed++; $display("FAIL b2b_head: st=%0h head=%h want 1 0d0d", fsm_state, head_flit_out); end
    tests_run++; if (addrhi_out !== 16'd0 || addrlo_out !== 16'd0 || data_out !== 128'd0) begin tests_failed++; $display("FAIL b2b_clear: hi=%h lo=%h want 0 0", addrhi_out, addrlo_out); end
    send(BD, 16'h0E0E); send(TL, 16'h0F0F);
    tests_run++; if (v_msg_out !== 1'b1 || addrlo_out !== 16'h0F0F) begin tests_failed++; $display("FAIL b2b_done: v=%b lo=%h want 1 0f0f", v_msg_out, addrlo_out); end
    ack();
  endtask

  task automatic test_errors();
    send(BD, 16'h9999);
    tests_run++; if (err_out !== 1'b1 || fsm_state !== S_IDLE) begin tests_failed++; $display("FAIL idle_body: err=%b st=%0h want 1 0", err_out, fsm_state); end
    send(IL, 16'h9999);
    tests_run++; if (err_out !== 1'b1 || fsm_state !== S_IDLE) begin tests_failed++; $display("FAIL idle_illegal: err=%b st=%0h want 1 0", err_out, fsm_state); end
    idle_cycle();
    tests_run++; if (err_out !== 1'b0) begin tests_failed++; $display("FAIL idle_pulse: err=%b want 0", err_out); end
    send(HD, 16'h4444); send(TL, 16'h5555);
    tests_run++; if (err_out !== 1'b1 || fsm_state !== S_IDLE || v_msg_out !== 1'b0) begin tests_failed++; $display("FAIL head_tail: err=%b st=%0h v=%b want 1 0 0", err_out, fsm_state, v_msg_out); end
    idle_cycle();
    tests_run++; if (err_out !== 1'b0 || v_msg_out !== 1'b0) begin tests_failed++; $display("FAIL head_tail_pulse: err=%b v=%b want 0 0", err_out, v_msg_out); end
  endtask

  task automatic test_overflow();
    send(HD, 16'h7000);
    for (int k = 1; k <= 10; k++) send(BD, 16'h7000 + 16'(k));
    tests_run++; if (fsm_state !== S_RECV || err_out !== 1'b0) begin tests_failed++; $display("FAIL ovf_11: st=%0h err=%b want 1 0", fsm_state, err_out); end
    tests_run++; if (data_out[127:112] !== 16'h700A) begin tests_failed++; $display("FAIL ovf_last: got %h want 700a", data_out[127:112]); end
    send(BD, 16'h700B);
    tests_run++; if (err_out !== 1'b1 || fsm_state !== S_DROP) begin tests_failed++; $display("FAIL ovf_12: err=%b st=%0h want 1 3", err_out, fsm_state); end
    send(BD, 16'h700C);
    tests_run++; if (err_out !== 1'b0 || fsm_state !== S_DROP) begin tests_failed++; $display("FAIL drop_body: err=%b st=%0h want 0 3", err_out, fsm_state); end
    send(HD, 16'h700D);
    tests_run++; if (err_out !== 1'b0 || fsm_state !== S_DROP || head_flit_out !== 16'h7000) begin tests_failed++; $display("FAIL drop_head: err=%b st=%0h head=%h want 0 3 7000", err_out, fsm_state, head_flit_out); end
    send(TL, 16'h700E);
    tests_run++; if (err_out !== 1'b0 || fsm_state !== S_IDLE || v_msg_out !== 1'b0) begin tests_failed++; $display("FAIL drop_tail: err=%b st=%0h v=%b want 0 0 0", err_out, fsm_state, v_msg_out); end
  endtask

  task automatic test_done_hold();
    send(HD, 16'h1357); send(BD, 16'h2468); send(TL, 16'h3579);
    @(negedge clk);
    v_flit_in = 1'b1; ctrl_in = HD; flit_in = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++; if (rdy_out !== 1'b0 || fsm_state !== S_DONE || head_flit_out !== 16'h1357 || addrlo_out !== 16'h3579 || flit_cnt_out !== 4'd3 || err_out !== 1'b0) begin
        tests_failed++; $display("FAIL done_hold%0d: rdy=%b st=%0h head=%h lo=%h cnt=%0d err=%b", i, rdy_out, fsm_state, head_flit_out, addrlo_out, flit_cnt_out, err_out);
      end
    end
    @(negedge clk); msg_ack_in = 1'b1;
    @(posedge clk); #1;
    msg_ack_in = 1'b0; v_flit_in = 1'b0; ctrl_in = IL;
    tests_run++; if (fsm_state !== S_IDLE || head_flit_out !== 16'h1357) begin tests_failed++; $display("FAIL done_ack_noflit: st=%0h head=%h want 0 1357", fsm_state, head_flit_out); end
    send(HD, 16'h0101); send(BD, 16'h0202);
    send(HD, 16'h0303);
    tests_run++; if (err_out !== 1'b1 || fsm_state !== S_RECV || head_flit_out !== 16'h0303 || addrhi_out !== 16'd0) begin tests_failed++; $display("FAIL restart: err=%b st=%0h head=%h hi=%h", err_out, fsm_state, head_flit_out, addrhi_out); end
    send(IL, 16'hDEAD);
    tests_run++; if (err_out !== 1'b1 || fsm_state !== S_RECV || addrhi_out !== 16'd0) begin tests_failed++; $display("FAIL recv_illegal: err=%b st=%0h hi=%h want 1 1 0", err_out, fsm_state, addrhi_out); end
    send(BD, 16'h0404); send(TL, 16'h0505);
    tests_run++; if (v_msg_out !== 1'b1 || addrhi_out !== 16'h0404 || addrlo_out !== 16'h0505 || flit_cnt_out !== 4'd3) begin tests_failed++; $display("FAIL restart_done: v=%b hi=%h lo=%h cnt=%0d", v_msg_out, addrhi_out, addrlo_out, flit_cnt_out); end
    ack();
  endtask

  task automatic test_reset_mid();
    send(HD, 16'h5A5A); send(BD, 16'h6B6B);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    tests_run++; if (fsm_state !== S_IDLE || rdy_out !== 1'b1 || v_msg_out !== 1'b0 || err_out !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_state: st=%0h rdy=%b v=%b err=%b", fsm_state, rdy_out, v_msg_out, err_out); end
    tests_run++; if ({head_flit_out, addrhi_out, addrlo_out, data_out, flit_cnt_out} !== 180'd0) begin tests_failed++; $display("FAIL rst_mid_regs: head=%h hi=%h want 0 0", head_flit_out, addrhi_out); end
    @(negedge clk); rst = 1'b1;
    send(HD, 16'h00FF); send(BD, 16'h0A0A); send(BD, 16'h0B0B); send(TL, 16'h0C0C);
    tests_run++; if (v_msg_out !== 1'b1 || head_flit_out !== 16'h00FF || addrhi_out !== 16'h0A0A || addrlo_out !== 16'h0B0B) begin tests_failed++; $display("FAIL rst_post_msg: v=%b head=%h hi=%h lo=%h", v_msg_out, head_flit_out, addrhi_out, addrlo_out); end
    tests_run++; if (data_out !== {112'd0, 16'h0C0C} || flit_cnt_out !== 4'd4) begin tests_failed++; $display("FAIL rst_post_data: data=%h cnt=%0d want 0c0c 4", data_out, flit_cnt_out); end
    ack();
  endtask

  initial begin
    test_reset();
    test_short_msg();
    test_full_msg();
    test_back_to_back();
    test_errors();
    test_overflow();
    test_done_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/download_fsm_datapath.md
DOWNLOAD_FSM_DATAPATH -- requirements
Module: download_fsm_datapath

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  asynchronous active-low reset.
REQ-003 SHALL: v_flit_in  input  1  flit_in/ctrl_in valid this cycle.
REQ-004 SHALL: flit_in  input  16  incoming flit from network-side FIFO.
REQ-005 SHALL: ctrl_in  input  2  flit type: 01 head, 10 body, 11 tail, 00 illegal.
REQ-006 SHALL: msg_ack_in  input  1  consumer takes the assembled message.
REQ-007 SHALL: rdy_out  output  1  block can accept a flit this cycle.
REQ-008 SHALL: v_msg_out  output  1  complete message held on message outputs.
REQ-009 SHALL: head_flit_out  output  16  flit 0 of message.
REQ-010 SHALL: addrhi_out  output  16  flit 1 of message.
REQ-011 SHALL: addrlo_out  output  16  flit 2 of message.
REQ-012 SHALL: data_out  output  128  data flit k (k=0..7, message flit 3+k) at bits [16k+15:16k].
REQ-013 SHALL: flit_cnt_out  output  4  total flits in message (3..11).
REQ-014 SHALL: fsm_state  output  2  current state encoding.
REQ-015 SHALL: err_out  output  1  one-cycle protocol-error pulse.

Function
REQ-016 SHALL: flit accepted on rising edge where v_flit_in=1 and rdy_out=1; otherwise flit_in/ctrl_in ignored.
REQ-017 SHALL: states IDLE=00, RECV=01, DONE=10, DROP=11; fsm_state equals state register.
REQ-018 SHALL: rdy_out=1 in IDLE, RECV, DROP; rdy_out=0 in DONE (combinational from state).
REQ-019 SHALL: v_msg_out=1 exactly when state=DONE.
REQ-020 SHALL: IDLE + accepted head: head_flit_out<=flit_in, addrhi/addrlo/data cleared to 0, cnt<=1, -> RECV.
REQ-021 SHALL: IDLE + accepted body/tail/00: flit discarded, err_out pulse, stay IDLE.
REQ-022 SHALL: RECV + accepted body or tail: flit stored at index cnt (1 addrhi, 2 addrlo, 3..10 data word cnt-3), cnt<=cnt+1.
REQ-023 SHALL: RECV + tail with new count >=3: -> DONE, flit_cnt_out<=new count.
REQ-024 SHALL: RECV + tail with new count <3 (short message): err_out pulse, -> IDLE, no v_msg_out.
REQ-025 SHALL: RECV + body arriving when cnt=10 making count 11 without tail: flit stored, -> DROP is NOT taken; the 11th flit must be tail; a body at cnt=10 stores then next non-tail flit triggers REQ-026.
REQ-026 SHALL: RECV + accepted body/tail when cnt=11: flit discarded, err_out pulse; body -> DROP, tail -> IDLE.
REQ-027 SHALL: RECV + accepted head: err_out pulse, message restarted per REQ-020 (stay RECV).
REQ-028 SHALL: RECV + accepted ctrl 00: flit discarded, err_out pulse, state/cnt unchanged.
REQ-029 SHALL: DROP: all accepted flits discarded; accepted tail -> IDLE; no further err pulses.
REQ-030 SHALL: DONE: message outputs stable; msg_ack_in=1 -> IDLE next edge (flit on same cycle not accepted since rdy_out=0).
REQ-031 SHALL: message registers hold value after DONE until next accepted head; msg_ack_in ignored outside DONE.
REQ-032 SHALL: cnt is 4-bit, saturates at 11, never wraps.
REQ-033 SHALL: minimum latency tail-accept edge to v_msg_out=1 is zero extra cycles (asserted in cycle following tail edge); back-to-back head accepted cycle after ack.

Reset
REQ-034 SHALL: rst=0 asynchronously forces state IDLE, cnt=0, all message registers 0, flit_cnt_out=0, err_out=0, v_msg_out=0; rdy_out=1.
REQ-035 SHALL: reset mid-message discards partial message; first flit after release must be head.

Verification
REQ-036 SHALL: head 0x1234, body 0xAAAA, tail 0x5555 -> v_msg_out=1, head=0x1234, addrhi=0xAAAA, addrlo=0x5555, data_out=0, flit_cnt_out=3.
REQ-037 SHALL: 11-flit message, data flits 0x0001..0x0008 -> data_out[15:0]=0x0001, [127:112]=0x0008, flit_cnt_out=11; ack -> IDLE, rdy_out=1.
REQ-038 SHALL: head then tail -> err_out one pulse, state IDLE, v_msg_out=0.
REQ-039 SHALL: 12 flits without tail, then tail -> err_out single pulse at 12th, DROP until tail, then IDLE.
REQ-040 SHALL: DONE held 5 cycles with v_flit_in=1 and no ack -> rdy_out=0, outputs unchanged; head in RECV restarts with err pulse.
REQ-041 SHALL: rst asserted after 2 flits -> all outputs zero immediately; post-release head 0x00FF+2 body+tail assembles correctly.
